// File: rtl/seq_detect_pkg.sv
// Shared constants and pattern helpers for the one-hot sequence detector.
// Patterns are passed zero-padded to MAX_PAT_W, so one helper set serves every DEPTH/SYM_W.
package seq_detect_pkg;

  localparam int IDLE_IDX  = 0;
  localparam int MAX_DEPTH = 8;
  localparam int MAX_SYM_W = 8;
  localparam int MAX_PAT_W = MAX_DEPTH * MAX_SYM_W;

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_LOAD,
    UPD_SYMBOL
  } upd_e;

  // Symbol k of a packed pattern, zero-extended to MAX_SYM_W bits.
  function automatic logic [MAX_SYM_W-1:0] sym(input logic [MAX_PAT_W-1:0] pattern,
                                               input int k, input int symW);
    logic [MAX_PAT_W-1:0] shifted;
    logic [MAX_SYM_W-1:0] mask;
    shifted = pattern >> (k * symW);
    mask    = ~({MAX_SYM_W{1'b1}} << symW);
    return shifted[MAX_SYM_W-1:0] & mask;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int border_len(input logic [MAX_PAT_W-1:0] pattern,
                                    input int depth, input int symW);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < MAX_DEPTH; j++) begin
      if (j < depth) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_DEPTH; i++) begin
          if (i < j && sym(pattern, i, symW) != sym(pattern, depth - j + i, symW)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_onehot_next.sv
// Combinational KMP-style next-state logic for the one-hot sequence detector.
module seq_next_state
  import seq_detect_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int DEPTH   = 4,
  parameter int OVERLAP = 1
) (
  input  logic [DEPTH*SYM_W-1:0] pat_i,
  input  logic [DEPTH-1:0]       state_i,
  input  logic [SYM_W-1:0]       sym_i,
  output logic [DEPTH-1:0]       state_o,
  output logic                   match_o
);

  logic [MAX_PAT_W-1:0] patWide;
  logic [MAX_SYM_W-1:0] symWide;
  logic                 ok;
  int                   nextIdx;

  // On a mismatch from state k, fall back to the longest j whose prefix still lines up with s.
  always_comb begin
    patWide = '0;
    patWide[DEPTH*SYM_W-1:0] = pat_i;
    symWide = '0;
    symWide[SYM_W-1:0] = sym_i;
    nextIdx = IDLE_IDX;
    match_o = 1'b0;
    ok      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (state_i[k]) begin
        if (sym(patWide, k, SYM_W) == symWide) begin
          if (k == DEPTH - 1) begin
            match_o = 1'b1;
            nextIdx = (OVERLAP != 0) ? border_len(patWide, DEPTH, SYM_W) : IDLE_IDX;
          end else begin
            nextIdx = k + 1;
          end
        end else begin
          for (int j = 1; j <= k; j++) begin
            ok = (sym(patWide, j - 1, SYM_W) == symWide);
            for (int i = 0; i < j - 1; i++) begin
              if (sym(patWide, i, SYM_W) != sym(patWide, k - j + 1 + i, SYM_W)) ok = 1'b0;
            end
            if (ok) nextIdx = j;
          end
        end
      end
    end
    for (int b = 0; b < DEPTH; b++) state_o[b] = (b == nextIdx);
  end

endmodule

// File: rtl/seq_detect_onehot.sv
// Runtime-loadable sequence recogniser with one-hot progress state,
// registered match pulse and a saturating match counter.
module seq_detect_onehot
  import seq_detect_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int DEPTH   = 4,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic                   load,
  input  logic [DEPTH*SYM_W-1:0] pattern,
  input  logic                   in_valid,
  input  logic [SYM_W-1:0]       in,
  output logic                   out,
  output logic [DEPTH-1:0]       state,
  output logic [CNT_W-1:0]       match_count
);

  localparam logic [DEPTH-1:0] IDLE_STATE = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH*SYM_W-1:0] pattern_q, pattern_d;
  logic [DEPTH-1:0]       state_q, state_d;
  logic                   out_q, out_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DEPTH-1:0]       nextState;
  logic                   matchHit;
  upd_e                   upd;

  seq_next_state #(
    .SYM_W  (SYM_W),
    .DEPTH  (DEPTH),
    .OVERLAP(OVERLAP)
  ) u_next (
    .pat_i  (pattern_q),
    .state_i(state_q),
    .sym_i  (in),
    .state_o(nextState),
    .match_o(matchHit)
  );

  // Load outranks a symbol, so a symbol arriving with load is simply dropped.
  always_comb begin
    upd = UPD_HOLD;
    if (load) upd = UPD_LOAD;
    else if (in_valid) upd = UPD_SYMBOL;
  end

  always_comb begin
    pattern_d = pattern_q;
    state_d   = state_q;
    out_d     = 1'b0;
    count_d   = count_q;
    case (upd)
      UPD_LOAD: begin
        pattern_d = pattern;
        state_d   = IDLE_STATE;
      end
      UPD_SYMBOL: begin
        state_d = nextState;
        out_d   = matchHit;
        if (matchHit && count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      pattern_q <= '0;
      state_q   <= IDLE_STATE;
      out_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      state_q   <= state_d;
      out_q     <= out_d;
      count_q   <= count_d;
    end
  end

  assign out         = out_q;
  assign state       = state_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_onehot.sv
// Scoreboard bench: stimulus tasks queue hand-computed results, a negedge monitor checks them.
module tb_seq_detect_onehot;

  logic       clk = 1'b0;
  logic       init = 1'b0, load = 1'b0, inValid = 1'b0;
  logic [7:0] pattern = '0;
  logic [1:0] inSym = '0;
  logic       outA, outB, outC;
  logic [3:0] stateA, stateB, stateC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;

  typedef struct {
    int         dut;
    int         id;
    logic [3:0] st;
    logic       o;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cur = 0;
  int   stepId = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  // A: overlapping, B: non-overlapping, C: overlapping with a 2-bit counter.
  seq_detect_onehot #(.SYM_W(2), .DEPTH(4), .OVERLAP(1), .CNT_W(8)) dutA (
    .clk(clk), .init(init), .load(load), .pattern(pattern), .in_valid(inValid),
    .in(inSym), .out(outA), .state(stateA), .match_count(cntA));

  seq_detect_onehot #(.SYM_W(2), .DEPTH(4), .OVERLAP(0), .CNT_W(8)) dutB (
    .clk(clk), .init(init), .load(load), .pattern(pattern), .in_valid(inValid),
    .in(inSym), .out(outB), .state(stateB), .match_count(cntB));

  seq_detect_onehot #(.SYM_W(2), .DEPTH(4), .OVERLAP(1), .CNT_W(2)) dutC (
    .clk(clk), .init(init), .load(load), .pattern(pattern), .in_valid(inValid),
    .in(inSym), .out(outC), .state(stateC), .match_count(cntC));

  task automatic checkOnehot(input logic [3:0] st, input string nm);
    checks++;
    if (!$onehot(st)) begin
      errors++;
      $display("[TB] FAIL onehot_%s state=%b required exactly one hot bit", nm, st);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] st;
    logic       o;
    int         c;
    case (e.dut)
      0:       begin st = stateA; o = outA; c = int'(cntA); end
      1:       begin st = stateB; o = outB; c = int'(cntB); end
      default: begin st = stateC; o = outC; c = int'(cntC); end
    endcase
    checks++;
    if (st !== e.st || o !== e.o || c != e.cnt) begin
      errors++;
      $display("[TB] FAIL step%0d dut%0d got state=%b out=%b cnt=%0d required state=%b out=%b cnt=%0d",
               e.id, e.dut, st, o, c, e.st, e.o, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checkOnehot(stateA, "A");
      checkOnehot(stateB, "B");
      checkOnehot(stateC, "C");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  task automatic applyStimulus(input logic i, input logic l, input logic [7:0] p,
                               input logic v, input logic [1:0] s,
                               input logic [3:0] es, input logic eo, input int ec);
    exp_t e;
    @(negedge clk);
    init = i; load = l; pattern = p; inValid = v; inSym = s;
    @(posedge clk);
    e.dut = cur; e.id = stepId; e.st = es; e.o = eo; e.cnt = ec;
    stepId++;
    sb.push_back(e);
  endtask

  task automatic doSym(input logic [1:0] s, input logic [3:0] es, input logic eo, input int ec);
    applyStimulus(1'b0, 1'b0, pattern, 1'b1, s, es, eo, ec);
  endtask

  task automatic doGap(input logic [3:0] es, input int ec);
    applyStimulus(1'b0, 1'b0, pattern, 1'b0, 2'b11, es, 1'b0, ec);
  endtask

  localparam logic [7:0] P_ALL01 = 8'h55;
  localparam logic [7:0] P_KMP   = 8'h25;

  initial begin
    // Reset with in_valid toggling, then load the all-01 pattern
    cur = 0;
    applyStimulus(1'b1, 1'b0, P_ALL01, 1'b1, 2'b01, 4'b0001, 1'b0, 0);
    started = 1'b1;
    applyStimulus(1'b1, 1'b0, P_ALL01, 1'b0, 2'b01, 4'b0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, P_ALL01, 1'b0, 2'b01, 4'b0001, 1'b0, 0);

    // Overlapping detection on a repeated symbol
    doSym(2'b01, 4'b0010, 1'b0, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doSym(2'b01, 4'b1000, 1'b0, 0);
    doSym(2'b01, 4'b1000, 1'b1, 1);
    doSym(2'b01, 4'b1000, 1'b1, 2);
    doSym(2'b01, 4'b1000, 1'b1, 3);
    doGap(4'b1000, 3);

    // Non-overlapping detection
    cur = 1;
    applyStimulus(1'b1, 1'b0, P_ALL01, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, P_ALL01, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    doSym(2'b01, 4'b0010, 1'b0, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doSym(2'b01, 4'b1000, 1'b0, 0);
    doSym(2'b01, 4'b0001, 1'b1, 1);
    doSym(2'b01, 4'b0010, 1'b0, 1);
    doSym(2'b01, 4'b0100, 1'b0, 1);

    // Fallback on mismatch, back to back
    cur = 0;
    applyStimulus(1'b1, 1'b0, P_KMP, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, P_KMP, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    doSym(2'b01, 4'b0010, 1'b0, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doSym(2'b10, 4'b1000, 1'b0, 0);
    doSym(2'b00, 4'b0001, 1'b1, 1);

    // Same stream with idle gaps
    applyStimulus(1'b1, 1'b0, P_KMP, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, P_KMP, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    doSym(2'b01, 4'b0010, 1'b0, 0);
    doGap(4'b0010, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doGap(4'b0100, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doGap(4'b0100, 0);
    doSym(2'b10, 4'b1000, 1'b0, 0);
    doGap(4'b1000, 0);
    doSym(2'b00, 4'b0001, 1'b1, 1);
    doGap(4'b0001, 1);
    doSym(2'b01, 4'b0010, 1'b0, 1);
    doSym(2'b11, 4'b0001, 1'b0, 1);

    // Load and reset in the middle of a sequence
    doSym(2'b01, 4'b0010, 1'b0, 1);
    doSym(2'b01, 4'b0100, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, P_KMP, 1'b1, 2'b10, 4'b0001, 1'b0, 1);
    doSym(2'b10, 4'b0001, 1'b0, 1);
    doSym(2'b01, 4'b0010, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, P_KMP, 1'b1, 2'b01, 4'b0001, 1'b0, 0);
    doSym(2'b00, 4'b0010, 1'b0, 0);

    // Saturating 2-bit counter
    cur = 2;
    applyStimulus(1'b1, 1'b0, P_ALL01, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, P_ALL01, 1'b0, 2'b00, 4'b0001, 1'b0, 0);
    doSym(2'b01, 4'b0010, 1'b0, 0);
    doSym(2'b01, 4'b0100, 1'b0, 0);
    doSym(2'b01, 4'b1000, 1'b0, 0);
    for (int n = 1; n <= 7; n++) doSym(2'b01, 4'b1000, 1'b1, (n < 3) ? n : 3);
    doGap(4'b1000, 3);

    for (int w = 0; w < 8 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_onehot.md
Name: seq_detect_onehot

Overview:
- Parametrised successor to the team's fixed 2-bit one-hot FSM.
- Detects a runtime-loadable sequence of DEPTH symbols, each SYM_W bits wide, on a valid-qualified symbol stream.
- Exposes its one-hot state and a match pulse, and keeps a saturating match counter.
- Used as a pattern/command recogniser ahead of control logic; overlapping or non-overlapping detection is selected by parameter.

Parameters:
- SYM_W, 2, symbol width in bits.
- DEPTH, 4, pattern length in symbols (range 2..8).
- OVERLAP, 1, 1 = a completed match may reuse its trailing symbols; 0 = restart from IDLE after a match.
- CNT_W, 8, match_count width.

Ports:
- clk  input  1  rising-edge clock.
- init  input  1  synchronous active-high reset.
- load  input  1  latch pattern and force state to IDLE.
- pattern  input  DEPTH*SYM_W  symbol k is at bits [k*SYM_W +: SYM_W]; symbol 0 is expected first.
- in_valid  input  1  qualifies in.
- in  input  SYM_W  stream symbol.
- out  output  1  one-cycle registered match pulse.
- state  output  DEPTH  one-hot; bit k set = k symbols currently matched (bit 0 = IDLE).
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- All registers update on the rising clk edge only.
- Reset (init=1), highest priority:
  - state <= 1 (IDLE).
  - out <= 0.
  - match_count <= 0.
  - pattern register <= 0.
  - A reset mid-sequence discards partial progress.
- Load (load=1, init=0):
  - pattern register <= pattern.
  - state <= IDLE; out <= 0; match_count unchanged.
  - A simultaneous in_valid symbol is dropped.
- Idle cycle (in_valid=0, no load/init): state and match_count hold; out <= 0.
- Symbol accepted (in_valid=1, no load/init), current state k, symbol s:
  - If k = DEPTH-1 and s = P[DEPTH-1] (completion):
    - out <= 1.
    - match_count <= match_count+1, saturating at 2^CNT_W-1.
    - Next state with OVERLAP=1: longest proper border of P, i.e. the largest j < DEPTH such that P[0..j-1] = P[DEPTH-j..DEPTH-1]; 0 if none.
    - Next state with OVERLAP=0: IDLE.
  - Else if s = P[k]: state <= k+1; out <= 0.
  - Else (mismatch, exact KMP fallback): state <= largest j in 1..k with P[0..j-2] = P[k-j+1..k-1] and P[j-1] = s; IDLE if no such j; out <= 0.
- Latency: out and match_count reflect the completing symbol one edge after it is presented. No combinational path from in to out.
- state is always exactly one-hot. The next-state logic never produces zero or multiple hot bits; the bench asserts this every cycle.
- An all-equal pattern with OVERLAP=1 gives a pulse on every valid symbol after the first DEPTH-1.

Decomposition:
- Package seq_detect_pkg:
  - IDLE index constant.
  - Function border_len(pattern) for the overlap restart state.
  - Function sym(pattern, k) for slicing.
- Sub-module seq_next_state: purely combinational; inputs are latched pattern, current one-hot state, symbol and OVERLAP; outputs are next one-hot state and a match flag.
- Top module: pattern, state, out and counter registers, plus init/load priority.

Test Plan (DEPTH=4, SYM_W=2, CNT_W=8 unless noted):
1. Reset: init=1 for 2 cycles with in_valid toggling -> state=4'b0001, out=0, match_count=0; init=0, load P=01,01,01,01 -> state=0001.
2. Overlap: OVERLAP=1, P=01,01,01,01, six valid 01 symbols -> state 0010,0100,1000, then pulses after symbols 4,5,6; state stays 1000; match_count=3.
3. Non-overlap: OVERLAP=0, same stream -> single pulse after symbol 4, then state 0010, 0100; match_count=1.
4. KMP fallback: P=01,01,10,00, stream 01,01,01,10,00 -> state after third 01 = 0100; pulse after 00; match_count=1. Gaps with in_valid=0 between symbols give the same result.
5. Load/reset mid-sequence: two matching symbols, then load with in_valid=1 -> state=0001, symbol dropped, count held. Repeat with init -> count=0.
6. Saturation: CNT_W=2, OVERLAP=1, all-01 pattern, 10 valid 01s -> match_count sticks at 3; out still pulses on every match.
